// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Word accesses from the core are looked up combinationally; a miss stalls
// the core while a dirty victim line is written back and the missing line is
// filled over the 128-bit datamem port.
//
// Handshake: the core raises cpu_req and holds every cpu_* input stable while
// cpu_stall is 1. The access completes in the first cycle with cpu_stall = 0.
// Toward datamem, mem_req is a registered one-cycle pulse. datamem answers
// with a one-cycle mem_ready pulse. mem_ready is only acted on in the WAIT
// states.
module dcache_ctrl #(
    parameter int NUM_SETS   = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [3:0]            cpu_be,
    input  logic [31:0]           cpu_wdata,
    output logic [31:0]           cpu_rdata,
    output logic                  cpu_stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [127:0]          mem_wdata,
    input  logic [127:0]          mem_rdata,
    input  logic                  mem_ready,
    output logic [2:0]            dbg_state
);

    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int TAG_W  = ADDR_WIDTH - 4 - IDX_W;
    localparam int LINE_W = ADDR_WIDTH - 4;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WB_REQ    = 3'd1,
        S_WB_WAIT   = 3'd2,
        S_FILL_REQ  = 3'd3,
        S_FILL_WAIT = 3'd4
    } state_t;

    state_t state_q, state_d;

    // Per-set storage: valid/dirty are reset, tag/data are not.
    logic [NUM_SETS-1:0] valid_q;
    logic [NUM_SETS-1:0] dirty_q;
    logic [TAG_W-1:0]    tag_q  [NUM_SETS];
    logic [127:0]        data_q [NUM_SETS];

    // Line address (tag + index) of the miss being serviced.
    logic [LINE_W-1:0]   miss_line_q;

    logic [IDX_W-1:0]    cpu_idx;
    logic [TAG_W-1:0]    cpu_tag;
    logic [1:0]          cpu_word;
    logic [IDX_W-1:0]    miss_idx;
    logic [TAG_W-1:0]    miss_tag;
    logic [127:0]        cur_line;
    logic [127:0]        merged_line;
    logic [LINE_W-1:0]   fill_line;
    logic                hit;
    logic                victim_dirty;
    logic                miss_start;
    logic                store_hit;
    logic                wb_done;
    logic                fill_done;
    logic                unused_addr_bits;

    assign cpu_idx          = cpu_addr[4 +: IDX_W];
    assign cpu_tag          = cpu_addr[ADDR_WIDTH-1 -: TAG_W];
    assign cpu_word         = cpu_addr[3:2];
    assign miss_idx         = miss_line_q[IDX_W-1:0];
    assign miss_tag         = miss_line_q[LINE_W-1 -: TAG_W];
    assign cur_line         = data_q[cpu_idx];
    assign hit              = cpu_req & valid_q[cpu_idx] & (tag_q[cpu_idx] == cpu_tag);
    assign victim_dirty     = valid_q[cpu_idx] & dirty_q[cpu_idx];
    assign unused_addr_bits = ^cpu_addr[1:0];
    assign dbg_state        = state_q;

    // Fill address comes straight from the core on a clean miss, otherwise
    // from the latched miss after the writeback has finished.
    assign fill_line = (state_q == S_IDLE) ? cpu_addr[ADDR_WIDTH-1:4] : miss_line_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; once a miss starts it runs to completion even if
    // cpu_req drops.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (miss_start) state_d = victim_dirty ? S_WB_REQ : S_FILL_REQ;
            S_WB_REQ:    state_d = S_WB_WAIT;
            S_WB_WAIT:   if (mem_ready) state_d = S_FILL_REQ;
            S_FILL_REQ:  state_d = S_FILL_WAIT;
            S_FILL_WAIT: if (mem_ready) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Output/control decode: core-facing outputs and array update strobes.
    always_comb begin
        miss_start = 1'b0;
        store_hit  = 1'b0;
        wb_done    = 1'b0;
        fill_done  = 1'b0;
        cpu_stall  = 1'b0;
        cpu_rdata  = 32'h0;
        if (cpu_req) begin
            cpu_stall = ~((state_q == S_IDLE) & hit);
            cpu_rdata = cur_line[32*int'(cpu_word) +: 32];
        end
        if (state_q == S_IDLE) begin
            miss_start = cpu_req & ~hit;
            store_hit  = hit & cpu_we;
        end
        if (state_q == S_WB_WAIT)   wb_done   = mem_ready;
        if (state_q == S_FILL_WAIT) fill_done = mem_ready;
    end

    // Store-hit merge: only the enabled bytes of the addressed word change.
    always_comb begin
        merged_line = cur_line;
        for (int b = 0; b < 4; b++) begin
            if (cpu_be[b]) merged_line[32*int'(cpu_word) + 8*b +: 8] = cpu_wdata[8*b +: 8];
        end
    end

    // Registered datamem request; address/data/we hold until the next request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_req <= 1'b0;
            if (miss_start && victim_dirty) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= {tag_q[cpu_idx], cpu_idx, 4'h0};
                mem_wdata <= cur_line;
            end else if (state_d == S_FILL_REQ && state_q != S_FILL_REQ) begin
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= {fill_line, 4'h0};
            end
        end
    end

    // Miss address latch plus valid/dirty bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_line_q <= '0;
            valid_q     <= '0;
            dirty_q     <= '0;
        end else begin
            if (miss_start) miss_line_q <= cpu_addr[ADDR_WIDTH-1:4];
            if (fill_done) begin
                valid_q[miss_idx] <= 1'b1;
                dirty_q[miss_idx] <= 1'b0;
            end else if (wb_done) begin
                dirty_q[miss_idx] <= 1'b0;
            end else if (store_hit) begin
                dirty_q[cpu_idx] <= 1'b1;
            end
        end
    end

    // Tag/data arrays: line fill or store-hit merge (never in the same cycle).
    always_ff @(posedge clk) begin
        if (fill_done) begin
            data_q[miss_idx] <= mem_rdata;
            tag_q[miss_idx]  <= miss_tag;
        end else if (store_hit) begin
            data_q[cpu_idx] <= merged_line;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed vector table, reset and
// cpu_req-drop sequences, then random accesses against a flat-memory model.
`timescale 1ns/1ps
module tb_dcache_ctrl;

    localparam int REC_W = 161;  // {we, line addr, line data}

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cpu_req, cpu_we;
    logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
    logic [3:0]   cpu_be;
    logic         cpu_stall;
    logic         mem_req, mem_we, mem_ready;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;
    logic [2:0]   dbg_state;

    int total = 0;
    int bad   = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    dcache_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_be(cpu_be),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .dbg_state(dbg_state)
    );

    // ---------------- datamem model ----------------
    logic [127:0]     mem_img [logic [31:0]];
    int               ready_delay = 0;
    logic [REC_W-1:0] act_q [$];
    logic [REC_W-1:0] exp_q [$];

    function automatic logic [127:0] init_line(input logic [31:0] a);
        if (a == 32'h0001_0000) return 128'hFFEEDDCC_BBAA9988_77665544_33221100;
        return {a ^ 32'h0C0C_0C0C, a ^ 32'h0808_0808, a ^ 32'h0404_0404, a ^ 32'h0101_0101};
    endfunction

    function automatic logic [127:0] img_line(input logic [31:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return init_line(a);
    endfunction

    // datamem: sample mem_req mid-cycle, answer with a one-cycle mem_ready
    initial begin
        logic [31:0]  a;
        logic         w;
        logic [127:0] d;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                a = mem_addr;
                w = mem_we;
                d = mem_wdata;
                act_q.push_back({w, a, w ? d : 128'h0});
                if (w) mem_img[a] = d;
                @(posedge clk);
                repeat (ready_delay) @(posedge clk);
                #1;
                mem_ready = 1'b1;
                mem_rdata = w ? 128'h0 : img_line(a);
                @(posedge clk);
                #1;
                mem_ready = 1'b0;
            end
        end
    end

    // ---------------- reference model ----------------
    // arch: lines the core has modified that datamem does not yet hold.
    // dm_ref: what datamem should contain. m_valid/m_tag: which line each set holds.
    logic [127:0] arch   [logic [31:0]];
    logic [127:0] dm_ref [logic [31:0]];
    bit           m_valid [256];
    logic [19:0]  m_tag   [256];

    function automatic logic [127:0] dm_line(input logic [31:0] a);
        if (dm_ref.exists(a)) return dm_ref[a];
        return init_line(a);
    endfunction

    function automatic logic [127:0] arch_line(input logic [31:0] a);
        if (arch.exists(a)) return arch[a];
        return dm_line(a);
    endfunction

    // Predict stall length and queue the expected datamem traffic.
    function automatic int model_access(input logic [31:0] addr);
        logic [31:0] line;
        logic [7:0]  s;
        logic [31:0] victim;
        int          st;
        line = {addr[31:4], 4'h0};
        s    = addr[11:4];
        st   = 3;
        if (m_valid[s] && m_tag[s] == addr[31:12]) return 0;
        victim = {m_tag[s], s, 4'h0};
        if (m_valid[s] && arch.exists(victim)) begin
            exp_q.push_back({1'b1, victim, arch[victim]});
            dm_ref[victim] = arch[victim];
            arch.delete(victim);
            st = 5;
        end
        exp_q.push_back({1'b0, line, 128'h0});
        m_valid[s] = 1'b1;
        m_tag[s]   = addr[31:12];
        return st;
    endfunction

    function automatic void model_store(input logic [31:0] addr, input logic [3:0] be,
                                        input logic [31:0] wd);
        logic [31:0]  line;
        logic [127:0] cur;
        line = {addr[31:4], 4'h0};
        cur  = arch_line(line);
        for (int b = 0; b < 4; b++)
            if (be[b]) cur[32*int'(addr[3:2]) + 8*b +: 8] = wd[8*b +: 8];
        arch[line] = cur;
    endfunction

    function automatic void model_reset();
        arch.delete();
        for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_txns(input string name);
        logic [REC_W-1:0] a, e;
        check({name, "_txn_count"}, 128'(act_q.size()), 128'(exp_q.size()));
        while (act_q.size() > 0 && exp_q.size() > 0) begin
            a = act_q.pop_front();
            e = exp_q.pop_front();
            check({name, "_txn_we"},   128'(a[160]),     128'(e[160]));
            check({name, "_txn_addr"}, 128'(a[159:128]), 128'(e[159:128]));
            check({name, "_txn_data"}, a[127:0],         e[127:0]);
        end
        act_q.delete();
        exp_q.delete();
    endtask

    // ---------------- driver ----------------
    // Entered and left at posedge+1. Holds the access until cpu_stall drops.
    task automatic run_access(input logic we, input logic [31:0] addr, input logic [3:0] be,
                              input logic [31:0] wd, input bit use_tab, input int tab_stall,
                              input logic [31:0] tab_rdata, input string name);
        int          exp_stall, stalls;
        logic [31:0] exp_rd, rd;
        bit          tmo;
        exp_stall = model_access(addr);
        exp_rd    = arch_line({addr[31:4], 4'h0})[32*int'(addr[3:2]) +: 32];
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_be = be; cpu_wdata = wd;
        stalls = 0;
        tmo    = 1'b0;
        while (1) begin
            @(negedge clk);
            if (!cpu_stall) break;
            stalls++;
            if (stalls >= 64) begin
                tmo = 1'b1;
                break;
            end
        end
        rd = cpu_rdata;
        @(posedge clk);
        #1;
        cpu_req = 1'b0; cpu_we = 1'b0;
        check({name, "_timeout"}, 128'(tmo), 128'(0));
        check({name, "_stall"}, 128'(stalls), 128'(exp_stall));
        if (!we) check({name, "_rdata"}, 128'(rd), 128'(exp_rd));
        if (use_tab) begin
            check({name, "_tab_stall"}, 128'(stalls), 128'(tab_stall));
            if (!we) check({name, "_tab_rdata"}, 128'(rd), 128'(tab_rdata));
        end
        if (we) model_store(addr, be, wd);
        check_txns(name);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          stall;
        logic [31:0] rdata;
    } vec_t;

    vec_t tab [6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        int n, st;
        tab[0] = '{1'b0, 32'h0001_0004, 4'h0, 32'h0,         3, 32'h7766_5544};
        tab[1] = '{1'b0, 32'h0001_0008, 4'h0, 32'h0,         0, 32'hBBAA_9988};
        tab[2] = '{1'b1, 32'h0001_0000, 4'b0010, 32'hDEAD_BEEF, 0, 32'h0};
        tab[3] = '{1'b0, 32'h0001_0000, 4'h0, 32'h0,         0, 32'h3322_BE00};
        tab[4] = '{1'b0, 32'h0001_1000, 4'h0, 32'h0,         5, 32'h0100_1101};
        tab[5] = '{1'b0, 32'h0001_0000, 4'h0, 32'h0,         3, 32'h3322_BE00};

        // reset
        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_be = '0; cpu_wdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_stall",     128'(cpu_stall), 128'(0));
        check("rst_rdata",     128'(cpu_rdata), 128'(0));
        check("rst_mem_req",   128'(mem_req),   128'(0));
        check("rst_mem_we",    128'(mem_we),    128'(0));
        check("rst_mem_addr",  128'(mem_addr),  128'(0));
        check("rst_mem_wdata", mem_wdata,       128'(0));
        check("rst_state",     128'(dbg_state), 128'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // directed table: fill, hit, partial store, dirty eviction, refill
        for (int i = 0; i < 6; i++)
            run_access(tab[i].we, tab[i].addr, tab[i].be, tab[i].wdata, 1'b1,
                       tab[i].stall, tab[i].rdata, $sformatf("tab%0d", i));
        check("t4_wb_line", img_line(32'h0001_0000), 128'hFFEEDDCC_BBAA9988_77665544_3322BE00);

        // reset during FILL_WAIT: late mem_ready ignored, dirty line lost
        run_access(1'b1, 32'h0001_0020, 4'hF, 32'h1234_5678, 1'b0, 0, 32'h0, "t5_dirty");
        ready_delay = 4;
        st = model_access(32'h0002_0010);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0002_0010;
        n = 0;
        while (dbg_state != 3'd4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t5_reach_fill_wait", 128'(dbg_state), 128'(4));
        check("t5_miss_kind", 128'(st), 128'(3));
        rst_n = 1'b0;
        cpu_req = 1'b0;
        model_reset();
        #1;
        check("t5_rst_state",   128'(dbg_state), 128'(0));
        check("t5_rst_mem_req", 128'(mem_req),   128'(0));
        check("t5_rst_addr",    128'(mem_addr),  128'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("t5_idle_after_late_ready", 128'(dbg_state), 128'(0));
        check_txns("t5");
        ready_delay = 0;
        run_access(1'b0, 32'h0002_0010, 4'h0, 32'h0, 1'b1, 3, 32'h0103_0111, "t5_reload");
        run_access(1'b0, 32'h0001_0020, 4'h0, 32'h0, 1'b1, 3, 32'h0100_0121, "t5_lost_wb");

        // cpu_req dropped in WB_WAIT: writeback and fill still complete
        run_access(1'b1, 32'h0001_3030, 4'hF, 32'hCAFE_F00D, 1'b0, 0, 32'h0, "t6_dirty");
        st = model_access(32'h0001_4030);
        check("t6_miss_kind", 128'(st), 128'(5));
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0001_4030;
        n = 0;
        while (dbg_state != 3'd2 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t6_reach_wb_wait", 128'(dbg_state), 128'(2));
        cpu_req = 1'b0;
        n = 0;
        while (dbg_state != 3'd0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t6_back_idle", 128'(dbg_state), 128'(0));
        @(posedge clk);
        #1;
        check_txns("t6");
        check("t6_wb_line", img_line(32'h0001_3030), {init_line(32'h0001_3030)[127:32], 32'hCAFE_F00D});
        run_access(1'b0, 32'h0001_4030, 4'h0, 32'h0, 1'b1, 0, 32'h0100_4131, "t6_valid");
        run_access(1'b0, 32'h0001_5030, 4'h0, 32'h0, 1'b1, 3, 32'h0100_5131, "t6_clean");

        // random accesses over 4 sets x 4 tags, with idle gaps
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = 32'h0001_0000 + ($urandom_range(0, 3) << 12) + ($urandom_range(0, 3) << 4)
                + $urandom_range(0, 15);
            if ($urandom_range(0, 4) == 0) begin
                cpu_req = 1'b0; cpu_we = 1'($urandom); cpu_addr = a;
                @(negedge clk);
                check("idle_stall", 128'(cpu_stall), 128'(0));
                check("idle_rdata", 128'(cpu_rdata), 128'(0));
                @(posedge clk);
                #1;
            end
            run_access(1'($urandom), a, 4'($urandom), $urandom, 1'b0, 0, 32'h0,
                       $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
